// File: rtl/traffic_attr_buffer.sv
// Header-attribute capture FIFO: filters accepted headers, timestamps them and queues records (FWFT).
// Define TRAFFIC_ATTR_STATS_EN to build the saturating accept/drop counters.
module traffic_attr_buffer #(
   parameter int         DEPTH_LOG2   = 4,
   parameter int         TIMESTAMP_W  = 32,
   parameter logic [7:0] FILTER_PROTO = 8'd17,
   parameter bit         FILTER_ANY   = 1'b1
) (
   input  logic                   clk125MHz,
   input  logic                   rst,
   input  logic                   s_hdr_valid,
   output logic                   s_hdr_ready,
   input  logic [15:0]            s_ip_length,
   input  logic [7:0]             s_ip_protocol,
   input  logic [15:0]            s_udp_source_port,
   input  logic [15:0]            s_udp_dest_port,
   input  logic                   s_payload_tvalid,
   output logic                   s_payload_tready,
   input  logic                   s_payload_tlast,
   output logic                   m_attr_valid,
   input  logic                   m_attr_ready,
   output logic [15:0]            m_attr_length,
   output logic [7:0]             m_attr_protocol,
   output logic [15:0]            m_attr_source_port,
   output logic [15:0]            m_attr_dest_port,
   output logic [TIMESTAMP_W-1:0] m_attr_timestamp,
   output logic [DEPTH_LOG2:0]    fill_level,
   output logic [15:0]            accept_count,
   output logic [15:0]            drop_count
);

   localparam int REC_W = 56 + TIMESTAMP_W;
   localparam logic [DEPTH_LOG2:0] DEPTH_L = {1'b1, {DEPTH_LOG2{1'b0}}};
   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_DRAIN = 1'b1;

   logic [0:0]             state_q, state_d;
   logic [DEPTH_LOG2-1:0]  wr_ptr_q, wr_ptr_d;
   logic [DEPTH_LOG2-1:0]  rd_ptr_q, rd_ptr_d;
   logic [DEPTH_LOG2:0]    fill_q, fill_d;
   logic [TIMESTAMP_W-1:0] ts_q, ts_d;
   logic [REC_W-1:0]       mem [DEPTH_L];
   logic [REC_W-1:0]       head;
   logic                   hdr_accept, hdr_match, full, empty, push, pop;

   always_comb begin
      hdr_accept = s_hdr_valid && (state_q == ST_IDLE);
      hdr_match  = FILTER_ANY || (s_ip_protocol == FILTER_PROTO);
      full       = (fill_q == DEPTH_L);
      empty      = (fill_q == '0);
      // Space is judged on the start-of-cycle fill, so a same-cycle pop never rescues a write.
      push       = hdr_accept && hdr_match && !full;
      pop        = !empty && m_attr_ready;

      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (hdr_accept && (s_ip_length > 16'd28)) state_d = ST_DRAIN;
         ST_DRAIN: if (s_payload_tvalid && s_payload_tlast) state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase

      wr_ptr_d = push ? wr_ptr_q + DEPTH_LOG2'(1) : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + DEPTH_LOG2'(1) : rd_ptr_q;
      fill_d   = fill_q;
      if (push && !pop)      fill_d = fill_q + (DEPTH_LOG2+1)'(1);
      else if (!push && pop) fill_d = fill_q - (DEPTH_LOG2+1)'(1);
      ts_d = ts_q + TIMESTAMP_W'(1);
   end

   always_ff @(posedge clk125MHz or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         fill_q   <= '0;
         ts_q     <= '0;
      end else begin
         state_q  <= state_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         fill_q   <= fill_d;
         ts_q     <= ts_d;
      end
   end

   // Record storage is not reset; the empty gate below hides stale contents.
   always_ff @(posedge clk125MHz) begin
      if (push)
         mem[wr_ptr_q] <= {s_ip_length, s_ip_protocol, s_udp_source_port, s_udp_dest_port, ts_q};
   end

   assign head = empty ? '0 : mem[rd_ptr_q];
   assign {m_attr_length, m_attr_protocol, m_attr_source_port, m_attr_dest_port, m_attr_timestamp} = head;
   assign m_attr_valid     = !empty;
   assign fill_level       = fill_q;
   assign s_hdr_ready      = (state_q == ST_IDLE);
   assign s_payload_tready = (state_q == ST_DRAIN);

`ifdef TRAFFIC_ATTR_STATS_EN
   logic [15:0] accept_q, accept_d, drop_q, drop_d;
   logic        drop;

   always_comb begin
      drop     = hdr_accept && hdr_match && full;
      accept_d = (push && accept_q != 16'hFFFF) ? accept_q + 16'd1 : accept_q;
      drop_d   = (drop && drop_q != 16'hFFFF) ? drop_q + 16'd1 : drop_q;
   end

   always_ff @(posedge clk125MHz or posedge rst) begin
      if (rst) begin
         accept_q <= '0;
         drop_q   <= '0;
      end else begin
         accept_q <= accept_d;
         drop_q   <= drop_d;
      end
   end

   assign accept_count = accept_q;
   assign drop_count   = drop_q;
`else
   assign accept_count = '0;
   assign drop_count   = '0;
`endif

endmodule

// File: tb/tb_traffic_attr_buffer.sv
// Scoreboard bench for traffic_attr_buffer (depth 4, protocol 17 filter); stats checks follow TRAFFIC_ATTR_STATS_EN.
module tb_traffic_attr_buffer;
   localparam int DEPTH = 4;
`ifdef TRAFFIC_ATTR_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   typedef struct packed {
      logic [15:0] len;
      logic [7:0]  proto;
      logic [15:0] sp;
      logic [15:0] dp;
      logic [31:0] ts;
   } rec_t;

   logic        clk125MHz = 1'b0;
   logic        rst = 1'b1;
   logic        s_hdr_valid = 1'b0, s_hdr_ready;
   logic [15:0] s_ip_length = '0, s_udp_source_port = '0, s_udp_dest_port = '0;
   logic [7:0]  s_ip_protocol = '0;
   logic        s_payload_tvalid = 1'b0, s_payload_tready, s_payload_tlast = 1'b0;
   logic        m_attr_valid, m_attr_ready = 1'b0;
   logic [15:0] m_attr_length, m_attr_source_port, m_attr_dest_port;
   logic [7:0]  m_attr_protocol;
   logic [31:0] m_attr_timestamp;
   logic [2:0]  fill_level;
   logic [15:0] accept_count, drop_count;

   rec_t        exp_q[$];
   int          checks = 0;
   int          failures = 0;
   int          exp_acc = 0;
   int          exp_drop = 0;
   int          rdy_pct = 100;
   logic [31:0] tb_cyc;

   traffic_attr_buffer #(.DEPTH_LOG2(2), .TIMESTAMP_W(32), .FILTER_PROTO(8'd17), .FILTER_ANY(1'b0)) dut (
      .clk125MHz(clk125MHz), .rst(rst),
      .s_hdr_valid(s_hdr_valid), .s_hdr_ready(s_hdr_ready),
      .s_ip_length(s_ip_length), .s_ip_protocol(s_ip_protocol),
      .s_udp_source_port(s_udp_source_port), .s_udp_dest_port(s_udp_dest_port),
      .s_payload_tvalid(s_payload_tvalid), .s_payload_tready(s_payload_tready),
      .s_payload_tlast(s_payload_tlast),
      .m_attr_valid(m_attr_valid), .m_attr_ready(m_attr_ready),
      .m_attr_length(m_attr_length), .m_attr_protocol(m_attr_protocol),
      .m_attr_source_port(m_attr_source_port), .m_attr_dest_port(m_attr_dest_port),
      .m_attr_timestamp(m_attr_timestamp), .fill_level(fill_level),
      .accept_count(accept_count), .drop_count(drop_count)
   );

   always #4 clk125MHz = ~clk125MHz;

   // Reference time base: cycles elapsed since reset release.
   always @(posedge clk125MHz or posedge rst) begin
      if (rst) tb_cyc <= '0;
      else     tb_cyc <= tb_cyc + 32'd1;
   end

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk125MHz);
      #1;
      m_attr_ready = ($urandom_range(0, 99) < rdy_pct);
   endtask

   task automatic check_stats();
      check("accept_count", 128'(accept_count), STATS ? 128'(exp_acc) : 128'(0));
      check("drop_count", 128'(drop_count), STATS ? 128'(exp_drop) : 128'(0));
   endtask

   task automatic send_frame(input logic [15:0] len, input logic [7:0] proto,
                             input logic [15:0] sp, input logic [15:0] dp, input int beats);
      rec_t r;
      bit   do_push;
      int   sent;
      bit   v;
      check("hdr_ready_idle", 128'(s_hdr_ready), 128'(1));
      check("tready_idle", 128'(s_payload_tready), 128'(0));
      s_hdr_valid = 1'b1; s_ip_length = len; s_ip_protocol = proto;
      s_udp_source_port = sp; s_udp_dest_port = dp;
      s_payload_tvalid = 1'($urandom_range(0, 1));
      s_payload_tlast  = 1'($urandom_range(0, 1));
      do_push = 1'b0;
      r = {len, proto, sp, dp, tb_cyc};
      if (proto == 8'd17) begin
         if (exp_q.size() < DEPTH) begin
            do_push = 1'b1;
            if (exp_acc < 65535) exp_acc++;
         end else if (exp_drop < 65535) exp_drop++;
      end
      tick();
      if (do_push) exp_q.push_back(r);
      s_hdr_valid = 1'b0; s_payload_tvalid = 1'b0; s_payload_tlast = 1'b0;
      if (len > 16'd28) begin
         sent = 0;
         while (sent < beats) begin
            v = ($urandom_range(0, 3) != 0);
            s_payload_tvalid = v;
            s_payload_tlast  = v && (sent == beats - 1);
            check("drain_ports", {126'(0), s_payload_tready, s_hdr_ready}, 128'b10);
            tick();
            if (v) sent++;
         end
         s_payload_tvalid = 1'b0; s_payload_tlast = 1'b0;
      end
   endtask

   task automatic drain_all();
      int n = 0;
      rdy_pct = 100;
      m_attr_ready = 1'b1;
      while (exp_q.size() != 0 && n < 50) begin
         tick();
         n++;
      end
      check("drain_timeout", 128'(exp_q.size()), 128'(0));
   endtask

   // Monitor: every cycle compare occupancy, and on each pop compare the head record.
   always @(negedge clk125MHz) begin
      rec_t e;
      if (!rst) begin
         check("fill_level", 128'(fill_level), 128'(exp_q.size()));
         check("m_attr_valid", 128'(m_attr_valid), 128'(exp_q.size() != 0));
         if (!m_attr_valid)
            check("idle_data", 128'({m_attr_length, m_attr_protocol, m_attr_source_port,
                                     m_attr_dest_port, m_attr_timestamp}), 128'(0));
         if (m_attr_valid && m_attr_ready && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("record", 128'({m_attr_length, m_attr_protocol, m_attr_source_port,
                                  m_attr_dest_port, m_attr_timestamp}), 128'(e));
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

   initial begin
      logic [15:0] lens [5];
      logic [7:0]  protos [4];
      lens[0] = 16'd20; lens[1] = 16'd28; lens[2] = 16'd29; lens[3] = 16'd60; lens[4] = 16'd0;
      protos[0] = 8'd17; protos[1] = 8'd17; protos[2] = 8'd6; protos[3] = 8'd1;

      repeat (3) @(posedge clk125MHz);
      #1;
      check("rst_valid", 128'(m_attr_valid), 128'(0));
      check("rst_fill", 128'(fill_level), 128'(0));
      check("rst_hdr_ready", 128'(s_hdr_ready), 128'(1));
      check("rst_tready", 128'(s_payload_tready), 128'(0));
      check("rst_data", 128'({m_attr_length, m_attr_protocol, m_attr_timestamp}), 128'(0));
      check_stats();
      rst = 1'b0;
      m_attr_ready = 1'b1;

      // Single UDP frame, first acceptance at timestamp 0
      send_frame(16'd60, 8'd17, 16'd1234, 16'd80, 4);
      // Minimum-length headers back to back
      send_frame(16'd28, 8'd17, 16'd1, 16'd2, 0);
      send_frame(16'd28, 8'd17, 16'd3, 16'd4, 0);
      // Filtered protocol: drained, not stored, not dropped
      send_frame(16'd60, 8'd6, 16'd5, 16'd6, 3);
      send_frame(16'd40, 8'd17, 16'd7, 16'd8, 2);
      drain_all();
      check_stats();

      // Overflow: 6 matching frames into a depth-4 FIFO with no reader
      rdy_pct = 0;
      m_attr_ready = 1'b0;
      for (int i = 0; i < 6; i++) send_frame(16'(29 + i), 8'd17, 16'(100 + i), 16'(200 + i), 1);
      check("full_fill", 128'(fill_level), 128'(4));
      check_stats();
      // Full with simultaneous pop: header still dropped
      m_attr_ready = 1'b1;
      rdy_pct = 0;
      send_frame(16'd20, 8'd17, 16'd9, 16'd9, 0);
      check("pop_while_full_fill", 128'(fill_level), 128'(3));
      check_stats();
      drain_all();

      // Reset in the middle of a drain with three stored records
      rdy_pct = 0;
      m_attr_ready = 1'b0;
      for (int i = 0; i < 3; i++) send_frame(16'd20, 8'd17, 16'(300 + i), 16'd1, 0);
      check("pre_reset_fill", 128'(fill_level), 128'(3));
      s_hdr_valid = 1'b1; s_ip_length = 16'd100; s_ip_protocol = 8'd6;
      tick();
      m_attr_ready = 1'b0;
      s_hdr_valid = 1'b0;
      s_payload_tvalid = 1'b1;
      tick();
      m_attr_ready = 1'b0;
      check("mid_drain_tready", 128'(s_payload_tready), 128'(1));
      #1 rst = 1'b1;
      #1;
      check("arst_valid", 128'(m_attr_valid), 128'(0));
      check("arst_fill", 128'(fill_level), 128'(0));
      check("arst_hdr_ready", 128'(s_hdr_ready), 128'(1));
      check("arst_tready", 128'(s_payload_tready), 128'(0));
      exp_q.delete();
      exp_acc = 0;
      exp_drop = 0;
      check_stats();
      s_payload_tvalid = 1'b0;
      @(posedge clk125MHz);
      #1 rst = 1'b0;
      rdy_pct = 100;
      m_attr_ready = 1'b1;
      send_frame(16'd60, 8'd17, 16'd42, 16'd43, 2);
      drain_all();

      // Randomized traffic with random reader back-pressure
      for (int f = 0; f < 200; f++) begin
         logic [15:0] l;
         l = lens[$urandom_range(0, 4)];
         if (l == 16'd0) l = 16'($urandom_range(0, 1500));
         rdy_pct = $urandom_range(0, 100);
         send_frame(l, protos[$urandom_range(0, 3)], 16'($urandom), 16'($urandom),
                    $urandom_range(1, 4));
         repeat ($urandom_range(0, 2)) tick();
      end
      drain_all();
      check_stats();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
